// File: rtl/program_counter_stack.sv
// Program counter with load, relative branch and call/return through a return-address stack.
// Define PC_STACK_GUARD_EN to suppress overflowing calls and underflowing returns and flag them on stack_err.
module program_counter_stack #(
    parameter int ADDR_WIDTH   = 22,
    parameter int BUS_WIDTH    = 32,
    parameter int REL_WIDTH    = 16,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BUS_WIDTH-1:0]           DATA_IN,
    input  logic                           pc_in,
    input  logic                           pc_call,
    input  logic                           pc_ret,
    input  logic                           pc_branch,
    input  logic                           pc_increment,
    input  logic                           pc_out,
    output logic [BUS_WIDTH-1:0]           DATA_OUT,
    output logic [ADDR_WIDTH-1:0]          pc_value,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           stack_full,
    output logic                           stack_empty,
    output logic                           stack_err
);

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam int DW  = SPW + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                  push;
    logic [ADDR_WIDTH-1:0] pcPlusOne;
    logic [ADDR_WIDTH-1:0] offsetExt;
    logic [ADDR_WIDTH-1:0] loadValue;
    logic                  full;
    logic                  empty;
    logic                  unusedBusBits;

    assign pcPlusOne     = pc_q + ADDR_WIDTH'(1);
    assign offsetExt     = ADDR_WIDTH'($signed(DATA_IN[REL_WIDTH-1:0]));
    assign loadValue     = DATA_IN[ADDR_WIDTH-1:0];
    assign full          = (depth_q == DW'(STACK_DEPTH));
    assign empty         = (depth_q == '0);
    assign unusedBusBits = ^DATA_IN[BUS_WIDTH-1:ADDR_WIDTH];

`ifdef PC_STACK_GUARD_EN
    logic err_q, err_d;
`endif

    // Priority chain: load > call > return > branch > increment; only the winner acts.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        push    = 1'b0;
`ifdef PC_STACK_GUARD_EN
        err_d   = err_q;
`endif
        if (pc_in) begin
            pc_d = loadValue;
        end else if (pc_call) begin
`ifdef PC_STACK_GUARD_EN
            if (full) begin
                err_d = 1'b1;
            end else begin
                push    = 1'b1;
                pc_d    = loadValue;
                sp_d    = sp_q + SPW'(1);
                depth_d = depth_q + DW'(1);
            end
`else
            push = 1'b1;
            pc_d = loadValue;
            sp_d = sp_q + SPW'(1);
            if (!full) begin
                depth_d = depth_q + DW'(1);
            end
`endif
        end else if (pc_ret) begin
`ifdef PC_STACK_GUARD_EN
            if (empty) begin
                err_d = 1'b1;
            end else begin
                pc_d    = stack_q[sp_q - SPW'(1)];
                sp_d    = sp_q - SPW'(1);
                depth_d = depth_q - DW'(1);
            end
`else
            // Without the guard an empty return still pops, reading whatever stale entry sits below sp.
            pc_d = stack_q[sp_q - SPW'(1)];
            sp_d = sp_q - SPW'(1);
            if (!empty) begin
                depth_d = depth_q - DW'(1);
            end
`endif
        end else if (pc_branch) begin
            pc_d = pc_q + offsetExt;
        end else if (pc_increment) begin
            pc_d = pcPlusOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
            sp_q    <= '0;
            depth_q <= '0;
`ifdef PC_STACK_GUARD_EN
            err_q   <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
`ifdef PC_STACK_GUARD_EN
            err_q   <= err_d;
`endif
        end
    end

    // Stack storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[sp_q] <= pcPlusOne;
        end
    end

    assign DATA_OUT    = pc_out ? BUS_WIDTH'(pc_q) : {BUS_WIDTH{1'bz}};
    assign pc_value    = pc_q;
    assign stack_depth = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
`ifdef PC_STACK_GUARD_EN
    assign stack_err   = err_q;
`else
    assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Bench for program_counter_stack: directed scenarios then random strobes against an integer reference model.
// Honours PC_STACK_GUARD_EN the same way the design does.
module tb_program_counter_stack;

    localparam int AW = 22;
    localparam int BW = 32;
    localparam int RW = 16;
    localparam int SD = 8;
    localparam int RV = 0;
    localparam longint MASK = (64'd1 << AW) - 1;

    logic          clk;
    logic          rst;
    logic [BW-1:0] dataIn;
    logic          pcIn, pcCall, pcRet, pcBranch, pcIncrement, pcOut;
    wire  [BW-1:0] dataOut;
    logic [AW-1:0] pcValue;
    logic [3:0]    stackDepth;
    logic          stackFull, stackEmpty, stackErr;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state in plain integers.
    longint mPc;
    longint mMem [SD];
    int     mSp;
    int     mDepth;
    bit     mErr;

    program_counter_stack #(
        .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .REL_WIDTH(RW),
        .STACK_DEPTH(SD), .RESET_VECTOR(RV)
    ) dut (
        .clk(clk), .rst(rst), .DATA_IN(dataIn),
        .pc_in(pcIn), .pc_call(pcCall), .pc_ret(pcRet),
        .pc_branch(pcBranch), .pc_increment(pcIncrement), .pc_out(pcOut),
        .DATA_OUT(dataOut), .pc_value(pcValue), .stack_depth(stackDepth),
        .stack_full(stackFull), .stack_empty(stackEmpty), .stack_err(stackErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    function automatic void modelStep(input bit r, input bit ld, input bit c, input bit rt,
                                      input bit b, input bit inc, input logic [BW-1:0] d);
        longint off;
        if (r) begin
            mPc = RV; mSp = 0; mDepth = 0; mErr = 0;
        end else if (ld) begin
            mPc = longint'(d) & MASK;
        end else if (c) begin
`ifdef PC_STACK_GUARD_EN
            if (mDepth == SD) mErr = 1;
            else begin
                mMem[mSp] = (mPc + 1) & MASK;
                mSp = (mSp + 1) % SD;
                mDepth++;
                mPc = longint'(d) & MASK;
            end
`else
            mMem[mSp] = (mPc + 1) & MASK;
            mSp = (mSp + 1) % SD;
            if (mDepth < SD) mDepth++;
            mPc = longint'(d) & MASK;
`endif
        end else if (rt) begin
`ifdef PC_STACK_GUARD_EN
            if (mDepth == 0) mErr = 1;
            else begin
                mSp = (mSp + SD - 1) % SD;
                mPc = mMem[mSp];
                mDepth--;
            end
`else
            mSp = (mSp + SD - 1) % SD;
            mPc = mMem[mSp];
            if (mDepth > 0) mDepth--;
`endif
        end else if (b) begin
            off = longint'(d) & ((64'd1 << RW) - 1);
            if (off >= (64'd1 << (RW - 1))) off = off - (64'd1 << RW);
            mPc = (mPc + off) & MASK;
        end else if (inc) begin
            mPc = (mPc + 1) & MASK;
        end
    endfunction

    // Drive one cycle of strobes, advance the model and compare every output just after the edge.
    task automatic applyStimulus(input bit r, input bit ld, input bit c, input bit rt,
                                 input bit b, input bit inc, input bit o, input logic [BW-1:0] d);
        logic [BW-1:0] expOut;
        rst = r; pcIn = ld; pcCall = c; pcRet = rt; pcBranch = b; pcIncrement = inc;
        pcOut = o; dataIn = d;
        modelStep(r, ld, c, rt, b, inc, d);
        @(posedge clk);
        #1;
        expOut = o ? BW'(mPc) : {BW{1'bz}};
        checkOutput("pc_value", BW'(pcValue), BW'(mPc));
        checkOutput("stack_depth", BW'(stackDepth), BW'(mDepth));
        checkOutput("stack_full", BW'(stackFull), BW'(mDepth == SD));
        checkOutput("stack_empty", BW'(stackEmpty), BW'(mDepth == 0));
        checkOutput("stack_err", BW'(stackErr), BW'(mErr));
        checkOutput("DATA_OUT", dataOut, expOut);
    endtask

    initial begin
        bit r, ld, c, rt, b, inc, o;
        logic [BW-1:0] d;
        logic [AW-1:0] pcBefore;

        // Reset wins over increment.
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h0);
        checkOutput("reset_pc", BW'(pcValue), BW'(RV));
        checkOutput("reset_empty", BW'(stackEmpty), 32'h1);

        // Wrap from max to zero, visible on the bus.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h003F_FFFF);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h0);
        checkOutput("wrap_pc", BW'(pcValue), 32'h0);
        checkOutput("wrap_bus", dataOut, 32'h0);

        // Relative branches backwards and forwards.
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h100);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'hABCD_FFF0);
        checkOutput("branch_back", BW'(pcValue), 32'hF0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0000_0010);
        checkOutput("branch_fwd", BW'(pcValue), 32'h100);

        // Nested call and return.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h10);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h200);
        checkOutput("call1_pc", BW'(pcValue), 32'h200);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h300);
        checkOutput("call2_depth", BW'(stackDepth), 32'h2);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0);
        checkOutput("ret1_pc", BW'(pcValue), 32'h201);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0);
        checkOutput("ret2_pc", BW'(pcValue), 32'h11);
        checkOutput("ret2_depth", BW'(stackDepth), 32'h0);

        // Call beats return and increment.
        applyStimulus(0, 0, 1, 1, 0, 1, 0, 32'h40);
        checkOutput("prio_pc", BW'(pcValue), 32'h40);
        checkOutput("prio_depth", BW'(stackDepth), 32'h1);

        // Fill the stack, overflow it, drain it, underflow it.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < SD; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h1000 + i * 16);
        checkOutput("fill_full", BW'(stackFull), 32'h1);
        pcBefore = pcValue;
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h5555);
`ifdef PC_STACK_GUARD_EN
        checkOutput("over_pc", BW'(pcValue), BW'(pcBefore));
        checkOutput("over_err", BW'(stackErr), 32'h1);
`else
        checkOutput("over_pc", BW'(pcValue), 32'h5555);
        checkOutput("over_depth", BW'(stackDepth), 32'h8);
`endif
        for (int i = 0; i < SD; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0);
        checkOutput("drain_empty", BW'(stackEmpty), 32'h1);
        pcBefore = pcValue;
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0);
`ifdef PC_STACK_GUARD_EN
        checkOutput("under_pc", BW'(pcValue), BW'(pcBefore));
        checkOutput("under_err", BW'(stackErr), 32'h1);
`else
        checkOutput("under_depth", BW'(stackDepth), 32'h0);
        checkOutput("under_err", BW'(stackErr), 32'h0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("err_cleared", BW'(stackErr), 32'h0);

        // Random strobes; every stack slot already holds a known value.
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            c   = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 3) == 0);
            inc = ($urandom_range(0, 1) == 0);
            o   = $urandom_range(0, 1) == 1;
            d   = $urandom;
            applyStimulus(r, ld, c, rt, b, inc, o, d);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
